// File: rtl/perceptron_vec.sv
// perceptron_vec: N-lane unsigned perceptron datapath behind a byte-stream
// command port.
//
// Frame format: SYNC byte, CMD byte, then exactly N*EB payload bytes (EB = W/8).
// The block holds operand vectors A and B, a wrapping accumulator ACC and a
// loadable threshold T. The output fire is the registered result of ACC >= T.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_data    command-stream byte
//   in_valid   in_data valid
//   in_ready   byte accepted when in_valid & in_ready (depends on state only)
//   out_data   response byte
//   out_valid  response valid; held with stable data until out_ready
//   out_ready  downstream accepts
//   busy       high while in EXEC or SEND
//   err        one-cycle pulse at the payload end of an unknown command
//   fire       registered (ACC >= T), unsigned compare
module perceptron_vec #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int GUARD = 4,
  parameter int SYNC  = 100,
  parameter int T_RST = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err,
  output logic       fire
);

  localparam int EB    = W / 8;
  localparam int ACC_W = 2 * W + $clog2(N) + GUARD;
  localparam int AB    = (ACC_W + 7) / 8;
  localparam int PL    = N * EB;
  localparam int KW    = $clog2(PL + 1);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int BW    = $clog2(AB + 1);

  localparam logic [7:0] SYNC_B = 8'(SYNC);

  localparam logic [7:0] CMD_LOAD_A = 8'h00;
  localparam logic [7:0] CMD_LOAD_B = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_LOAD_T = 8'h03;
  localparam logic [7:0] CMD_MUL    = 8'h05;
  localparam logic [7:0] CMD_MAC    = 8'h06;
  localparam logic [7:0] CMD_CLEAR  = 8'h07;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_PAY,
    S_EXEC,
    S_SEND
  } state_t;

  state_t state_q, state_nxt;

  logic [7:0]      cmd_q;
  logic [KW-1:0]   k_q;
  logic [IW-1:0]   i_q;
  logic [BW-1:0]   byte_q;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] t_q;
  logic [AB*8-1:0]  snap_q;
  logic [W-1:0]     a_q [N];
  logic [W-1:0]     b_q [N];
  logic             fire_q;
  logic             err_q;

  logic             accept;
  logic             pay_last;
  logic             lane_last;
  logic             send_last;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] sum_now;
  logic             cmd_known;

  assign pay_last  = (k_q == KW'(PL - 1));
  assign lane_last = (i_q == IW'(N - 1));
  assign send_last = (byte_q == BW'(AB));

  assign cmd_known = (cmd_q == CMD_LOAD_A) || (cmd_q == CMD_LOAD_B) ||
                     (cmd_q == CMD_READ)   || (cmd_q == CMD_LOAD_T) ||
                     (cmd_q == CMD_MUL)    || (cmd_q == CMD_MAC)    ||
                     (cmd_q == CMD_CLEAR);

  // One lane product per EXEC cycle, zero-extended to the accumulator width.
  assign prod    = (2 * W)'(a_q[i_q]) * (2 * W)'(b_q[i_q]);
  assign sum_now = sum_q + ACC_W'(prod);

  assign fire = fire_q;
  assign err  = err_q;

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = {7'b0, fire_q};

    unique case (state_q)
      S_HUNT, S_CMD, S_PAY: in_ready = 1'b1;
      S_EXEC:               busy     = 1'b1;
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase

    // ACC bytes come from the snapshot; the final byte carries fire.
    for (int unsigned j = 0; j < AB; j++) begin
      if (byte_q == BW'(j)) out_data = snap_q[j*8 +: 8];
    end

    accept = in_valid & in_ready;

    unique case (state_q)
      S_HUNT: if (accept && in_data == SYNC_B) state_nxt = S_CMD;
      S_CMD:  if (accept) state_nxt = S_PAY;
      S_PAY: begin
        if (accept && pay_last) begin
          if (cmd_q == CMD_MUL || cmd_q == CMD_MAC) state_nxt = S_EXEC;
          else if (cmd_q == CMD_READ)               state_nxt = S_SEND;
          else                                      state_nxt = S_HUNT;
        end
      end
      S_EXEC: if (lane_last) state_nxt = S_HUNT;
      S_SEND: if (out_ready && send_last) state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      cmd_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      byte_q  <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      t_q     <= ACC_W'(T_RST);
      snap_q  <= '0;
      fire_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned l = 0; l < N; l++) begin
        a_q[l] <= '0;
        b_q[l] <= '0;
      end
    end else begin
      state_q <= state_nxt;
      err_q   <= 1'b0;
      // Re-evaluated every cycle, so it tracks any change of ACC or T one
      // cycle later.
      fire_q  <= (acc_q >= t_q);

      unique case (state_q)
        S_CMD: begin
          if (accept) begin
            cmd_q <= in_data;
            k_q   <= '0;
          end
        end

        S_PAY: begin
          if (accept) begin
            k_q <= k_q + KW'(1);

            for (int unsigned l = 0; l < N; l++) begin
              for (int unsigned b = 0; b < EB; b++) begin
                if (32'(k_q) == l * EB + b) begin
                  if (cmd_q == CMD_LOAD_A) a_q[l][b*8 +: 8] <= in_data;
                  if (cmd_q == CMD_LOAD_B) b_q[l][b*8 +: 8] <= in_data;
                end
              end
            end

            // Bytes past the threshold width simply match no bit.
            if (cmd_q == CMD_LOAD_T) begin
              for (int unsigned j = 0; j < ACC_W; j++) begin
                if (32'(k_q) == j / 8) t_q[j] <= in_data[j % 8];
              end
            end

            if (pay_last) begin
              if (cmd_q == CMD_MUL || cmd_q == CMD_MAC) begin
                i_q   <= '0;
                sum_q <= '0;
              end
              if (cmd_q == CMD_READ) begin
                snap_q <= (AB * 8)'(acc_q);
                byte_q <= '0;
              end
              if (cmd_q == CMD_CLEAR) acc_q <= '0;
              if (!cmd_known) err_q <= 1'b1;
            end
          end
        end

        S_EXEC: begin
          i_q   <= i_q + IW'(1);
          sum_q <= sum_now;
          if (lane_last) begin
            if (cmd_q == CMD_MUL) acc_q <= sum_now;
            else                  acc_q <= acc_q + sum_now;
          end
        end

        S_SEND: begin
          if (out_ready) byte_q <= byte_q + BW'(1);
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_vec.sv
module tb_perceptron_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       sel;
  logic       bp;

  logic       in_ready0, out_valid0, busy0, err0, fire0;
  logic [7:0] out_data0;
  logic       in_ready1, out_valid1, busy1, err1, fire1;
  logic [7:0] out_data1;
  logic       in_valid0, in_valid1;

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  perceptron_vec #(.N(4), .W(8), .GUARD(4), .SYNC(100), .T_RST(256)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .busy(busy0), .err(err0), .fire(fire0)
  );

  perceptron_vec #(.N(4), .W(8), .GUARD(0), .SYNC(100), .T_RST(256)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1), .err(err1), .fire(fire1)
  );

  logic       in_ready_m, out_valid_m, busy_m, err_m, fire_m;
  logic [7:0] out_data_m;
  assign in_ready_m  = sel ? in_ready1  : in_ready0;
  assign out_valid_m = sel ? out_valid1 : out_valid0;
  assign busy_m      = sel ? busy1      : busy0;
  assign err_m       = sel ? err1       : err0;
  assign fire_m      = sel ? fire1      : fire0;
  assign out_data_m  = sel ? out_data1  : out_data0;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream: always ready, or ready one cycle in eleven under backpressure.
  int bp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!bp || bp_cnt == 10) begin
      out_ready = 1'b1;
      bp_cnt = 0;
    end else begin
      out_ready = 1'b0;
      bp_cnt++;
    end
  end

  // Response monitor and scoreboard, sampled on the falling edge.
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst && out_valid_m) begin
      check("in_ready_in_send", {31'b0, in_ready_m}, 32'd0);
      if (hold_prev) check("held_data_stable", {24'b0, out_data_m}, {24'b0, prev_data});
      if (out_ready) begin
        hold_prev = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'b0, out_data_m}, 32'hFFFF_FFFF);
        end else begin
          check("read_byte", {24'b0, out_data_m}, {24'b0, exp_q.pop_front()});
        end
      end else begin
        hold_prev = 1'b1;
        prev_data = out_data_m;
      end
    end else begin
      hold_prev = 1'b0;
    end
    if (!rst && err_m) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_m) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pl);
    logic [31:0] p;
    p = pl;
    send_byte(8'd100);
    send_byte(cmd);
    for (int j = 0; j < 4; j++) send_byte(p[j*8 +: 8]);
    in_valid = 1'b0;
  endtask

  // Waits for busy to drop and the scoreboard to drain; returns busy cycles.
  task automatic wait_idle(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (busy_m) busy_cycles++;
      else if (exp_q.size() == 0) break;
      n++;
      if (n > 2000) begin
        check("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int j = 0; j < 4; j++) exp_q.push_back(e[j*8 +: 8]);
    send_frame(8'h02, 32'h0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pl;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   bc;

  initial begin
    tbl[0]  = '{cmd: 8'h00, pl: 32'h04030201, exp: 32'h0};
    tbl[1]  = '{cmd: 8'h01, pl: 32'h281E140A, exp: 32'h0};
    tbl[2]  = '{cmd: 8'h05, pl: 32'h0,        exp: 32'h0};
    tbl[3]  = '{cmd: 8'h02, pl: 32'h0,        exp: 32'h0100012C};
    tbl[4]  = '{cmd: 8'h06, pl: 32'h0,        exp: 32'h0};
    tbl[5]  = '{cmd: 8'h02, pl: 32'h0,        exp: 32'h01000258};
    tbl[6]  = '{cmd: 8'h03, pl: 32'hFF010258, exp: 32'h0};
    tbl[7]  = '{cmd: 8'h02, pl: 32'h0,        exp: 32'h00000258};
    tbl[8]  = '{cmd: 8'h03, pl: 32'h00000258, exp: 32'h0};
    tbl[9]  = '{cmd: 8'h02, pl: 32'h0,        exp: 32'h01000258};
    tbl[10] = '{cmd: 8'h07, pl: 32'h0,        exp: 32'h0};
    tbl[11] = '{cmd: 8'h02, pl: 32'h0,        exp: 32'h00000000};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; sel = 1'b0; bp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready0},  32'd1);
    check("rst_out_valid", {31'b0, out_valid0}, 32'd0);
    check("rst_busy",      {31'b0, busy0},      32'd0);
    check("rst_err",       {31'b0, err0},       32'd0);
    check("rst_fire",      {31'b0, fire0},      32'd0);
    @(posedge clk);
    #1;

    // Load / MUL / MAC / threshold / CLEAR sequence.
    for (int v = 0; v < 12; v++) begin
      if (tbl[v].cmd == 8'h02) push_read(tbl[v].exp);
      else send_frame(tbl[v].cmd, tbl[v].pl);
      wait_idle(bc);
      if (tbl[v].cmd == 8'h05 || tbl[v].cmd == 8'h06) check("exec_cycles", bc, 32'd4);
    end

    // Unknown command after junk bytes; SYNC inside the payload is data.
    err_cnt = 0;
    send_byte(8'd7); send_byte(8'd9); send_byte(8'd100); send_byte(8'h09);
    send_byte(8'd1); send_byte(8'd100); send_byte(8'd3); send_byte(8'd4);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("err_pulses", err_cnt, 32'd1);
    push_read(32'h00000000);
    wait_idle(bc);
    send_frame(8'h05, 32'h0);
    wait_idle(bc);
    push_read(32'h0000012C);
    wait_idle(bc);

    // Backpressure on the response port.
    bp = 1'b1;
    push_read(32'h0000012C);
    wait_idle(bc);
    bp = 1'b0;
    @(posedge clk);
    #1;

    // Reset during the second EXEC cycle of a MAC.
    send_frame(8'h06, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready",  {31'b0, in_ready0},  32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid0}, 32'd0);
    check("mid_rst_busy",      {31'b0, busy0},      32'd0);
    check("mid_rst_fire",      {31'b0, fire0},      32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_no_bytes", exp_q.size(), 32'd0);
    send_frame(8'h07, 32'h0);
    wait_idle(bc);
    push_read(32'h00000000);
    wait_idle(bc);
    // A and B were cleared by reset and T is back to 256.
    send_frame(8'h05, 32'h0);
    wait_idle(bc);
    push_read(32'h00000000);
    wait_idle(bc);
    send_frame(8'h00, 32'h04030201);
    send_frame(8'h01, 32'h281E140A);
    send_frame(8'h05, 32'h0);
    wait_idle(bc);
    push_read(32'h0100012C);
    wait_idle(bc);

    // Accumulator wrap on the GUARD=0 instance (18-bit ACC).
    sel = 1'b1;
    send_frame(8'h00, 32'hFFFFFFFF);
    send_frame(8'h01, 32'hFFFFFFFF);
    send_frame(8'h05, 32'h0);
    wait_idle(bc);
    check("wrap_exec_cycles", bc, 32'd4);
    push_read(32'h0103F804);
    wait_idle(bc);
    send_frame(8'h06, 32'h0);
    wait_idle(bc);
    push_read(32'h0103F008);
    wait_idle(bc);
    check("wrap_fire", {31'b0, fire_m}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
